// File: rtl/gap_fc_head_pkg.sv
// Shared types and constants for the GAP classifier head and its MAC datapath.
package gap_fc_head_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        ISSUE,
        DRAIN,
        EMIT,
        DONE
    } fc_state_e;

    localparam int DEF_BW_ACT   = 12;
    localparam int DEF_BW_PARAM = 8;

    localparam int SAT_MAX = 2047;
    localparam int SAT_MIN = -2048;

    // Index width for an n-entry space; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gap_fc_head_fc_mac_acc.sv
// Signed multiply-accumulate with bias preload, arithmetic output shift and saturation.
module fc_mac_acc
    import gap_fc_head_pkg::*;
#(
    parameter int A_W    = DEF_BW_ACT,
    parameter int W_W    = DEF_BW_PARAM,
    parameter int ACC_BW = 25,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     acc_en,
    input  logic                     bias_ld,
    input  logic signed [A_W-1:0]    act_in,
    input  logic signed [W_W-1:0]    w_in,
    input  logic signed [W_W-1:0]    b_in,
    output logic signed [ACC_BW-1:0] acc_o,
    output logic signed [A_W-1:0]    sat_o
);

    localparam logic signed [ACC_BW-1:0] HI = ACC_BW'(SAT_MAX);
    localparam logic signed [ACC_BW-1:0] LO = ACC_BW'(SAT_MIN);

    logic signed [ACC_BW-1:0] acc_q, acc_d;
    logic signed [ACC_BW-1:0] a_ext, w_ext, b_ext, prod, base, shifted;

    always_comb begin
        a_ext = ACC_BW'(act_in);
        w_ext = ACC_BW'(w_in);
        b_ext = ACC_BW'(b_in);
        prod  = a_ext * w_ext;
        // The first channel of a class replaces the running sum with the bias.
        base  = bias_ld ? b_ext : acc_q;
        acc_d = acc_en ? (base + prod) : acc_q;
    end

    always_comb begin
        shifted = acc_q >>> SHIFT;
        if (shifted > HI)
            sat_o = A_W'(HI);
        else if (shifted < LO)
            sat_o = A_W'(LO);
        else
            sat_o = A_W'(shifted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/gap_fc_head.sv
// Classifier head: gathers one pooled activation per channel, runs the FC layer
// class by class against weight/bias SRAM, streams saturated scores, reports argmax.
module gap_fc_head
    import gap_fc_head_pkg::*;
#(
    parameter int CH_NUM       = 16,
    parameter int CLS_NUM      = 10,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = DEF_BW_ACT,
    parameter int BW_PER_PARAM = DEF_BW_PARAM,
    parameter int OUT_SHIFT    = 4,
    parameter int ACC_BW       = BW_PER_ACT + BW_PER_PARAM + $clog2(CH_NUM) + 1
) (
    input  logic                                   clk,
    input  logic                                   srst_n,
    input  logic                                   act_valid,
    output logic                                   act_ready,
    input  logic [ACT_PER_ADDR*BW_PER_ACT-1:0]     act_wdata,
    output logic                                   w_ren,
    output logic [addr_w(CH_NUM*CLS_NUM)-1:0]      w_addr,
    input  logic signed [BW_PER_PARAM-1:0]         w_rdata,
    output logic [addr_w(CLS_NUM)-1:0]             b_addr,
    input  logic signed [BW_PER_PARAM-1:0]         b_rdata,
    output logic                                   score_valid,
    output logic [addr_w(CLS_NUM)-1:0]             score_idx,
    output logic signed [BW_PER_ACT-1:0]           score_data,
    output logic                                   done,
    output logic [addr_w(CLS_NUM)-1:0]             class_id
);

    localparam int CH_W  = addr_w(CH_NUM);
    localparam int CLS_W = addr_w(CLS_NUM);
    localparam int WA_W  = addr_w(CH_NUM * CLS_NUM);
    localparam int WD_W  = ACT_PER_ADDR * BW_PER_ACT;

    fc_state_e                     state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [CLS_W-1:0]              cls_q, cls_d;
    logic                          rd_v_q, rd_v_d;
    logic [CH_W-1:0]               rd_i_q, rd_i_d;
    logic signed [BW_PER_ACT-1:0]  act_q [CH_NUM];
    logic signed [BW_PER_ACT-1:0]  act_d [CH_NUM];
    logic signed [BW_PER_ACT-1:0]  best_q, best_d;
    logic [CLS_W-1:0]              best_idx_q, best_idx_d;
    logic [CLS_W-1:0]              class_id_q, class_id_d;
    logic [CLS_W-1:0]              sidx_q, sidx_d;
    logic signed [BW_PER_ACT-1:0]  sdata_q, sdata_d;
    logic signed [ACC_BW-1:0]      mac_acc;
    logic signed [BW_PER_ACT-1:0]  mac_sat;
    logic                          unused_lo_bits;

    assign unused_lo_bits = ^act_wdata[WD_W-BW_PER_ACT-1:0];

    fc_mac_acc #(
        .A_W    (BW_PER_ACT),
        .W_W    (BW_PER_PARAM),
        .ACC_BW (ACC_BW),
        .SHIFT  (OUT_SHIFT)
    ) u_mac (
        .clk     (clk),
        .rst_n   (srst_n),
        .acc_en  (rd_v_q),
        .bias_ld (rd_i_q == '0),
        .act_in  (act_q[rd_i_q]),
        .w_in    (w_rdata),
        .b_in    (b_rdata),
        .acc_o   (mac_acc),
        .sat_o   (mac_sat)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cls_d       = cls_q;
        act_d       = act_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        class_id_d  = class_id_q;
        sidx_d      = sidx_q;
        sdata_d     = sdata_q;
        act_ready   = 1'b0;
        w_ren       = 1'b0;
        score_valid = 1'b0;
        done        = 1'b0;

        case (state_q)
            COLLECT: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    act_d[ch_q] = act_wdata[WD_W-1 -: BW_PER_ACT];
                    if (ch_q == CH_W'(CH_NUM - 1)) begin
                        ch_d    = '0;
                        cls_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            ISSUE: begin
                w_ren = 1'b1;
                if (ch_q == CH_W'(CH_NUM - 1)) begin
                    ch_d    = '0;
                    state_d = DRAIN;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            DRAIN: state_d = EMIT;
            EMIT: begin
                score_valid = 1'b1;
                sidx_d      = cls_q;
                sdata_d     = mac_sat;
                // Strict compare: on a tie the earlier class keeps the win.
                if (cls_q == '0 || mac_sat > best_q) begin
                    best_d     = mac_sat;
                    best_idx_d = cls_q;
                end
                if (cls_q == CLS_W'(CLS_NUM - 1)) begin
                    state_d = DONE;
                end else begin
                    cls_d   = cls_q + CLS_W'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                done       = 1'b1;
                class_id_d = best_idx_q;
                state_d    = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        // SRAM returns land one cycle after issue; tag them with their channel.
        rd_v_d = (state_q == ISSUE);
        rd_i_d = ch_q;
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= COLLECT;
            ch_q       <= '0;
            cls_q      <= '0;
            rd_v_q     <= 1'b0;
            rd_i_q     <= '0;
            act_q      <= '{default: '0};
            best_q     <= '0;
            best_idx_q <= '0;
            class_id_q <= '0;
            sidx_q     <= '0;
            sdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cls_q      <= cls_d;
            rd_v_q     <= rd_v_d;
            rd_i_q     <= rd_i_d;
            act_q      <= act_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            class_id_q <= class_id_d;
            sidx_q     <= sidx_d;
            sdata_q    <= sdata_d;
        end
    end

    assign w_addr     = w_ren ? (WA_W'(cls_q) * WA_W'(CH_NUM) + WA_W'(ch_q)) : '0;
    assign b_addr     = cls_q;
    assign score_idx  = score_valid ? cls_q : sidx_q;
    assign score_data = score_valid ? mac_sat : sdata_q;
    assign class_id   = class_id_q;

endmodule
